// File: rtl/program_counter_pkg.sv
// Shared processor definitions for the program counter: FSM state encoding,
// default widths and the saturating retire-count helper.
package program_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int PC_WIDTH_DEFAULT = 10;
    localparam int RETIRED_WIDTH    = 16;

    // The retired count sticks at all-ones instead of wrapping back to zero.
    function automatic logic [RETIRED_WIDTH-1:0] sat_inc(input logic [RETIRED_WIDTH-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Control/status bundle between the instruction-fetch sequencer and the
// program counter: launch/stall/halt/branch requests in, PC and status out.
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int PC_width = PC_WIDTH_DEFAULT
) ();

    logic                     Start;
    logic                     Stall;
    logic                     Halt;
    logic                     BranchEn;
    logic [PC_width-1:0]      Offset;
    logic [PC_width-1:0]      PC;
    logic                     Done;
    logic [RETIRED_WIDTH-1:0] Retired;

    modport master (
        output Start, Stall, Halt, BranchEn, Offset,
        input  PC, Done, Retired
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, Offset,
        output PC, Done, Retired
    );

endinterface

// File: rtl/pc_adder.sv
// Wrap-around PC adder shared by the sequential (+1) and relative-branch targets.
module pc_adder #(
    parameter int PC_width = 10
) (
    input  logic [PC_width-1:0] a,
    input  logic [PC_width-1:0] b,
    output logic [PC_width-1:0] sum
);

    // Carry out is dropped on purpose so the PC wraps silently in both directions.
    assign sum = a + b;

endmodule

// File: rtl/program_counter.sv
// Program counter with IDLE/RUN/HALT sequencing, relative branches, stall,
// and a saturating retired-instruction counter; all outputs come from flops.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int PC_width   = PC_WIDTH_DEFAULT,
    parameter int START_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    program_counter_if.slave  bus
);

    localparam logic [PC_width-1:0] START_PC = PC_width'(START_ADDR);

    pc_state_e                state_reg;
    logic [PC_width-1:0]      pc_reg;
    logic                     done_reg;
    logic [RETIRED_WIDTH-1:0] retired_reg;
    logic [PC_width-1:0]      step;
    logic [PC_width-1:0]      pc_next;

    // A taken branch adds the signed offset; otherwise advance by one.
    assign step = bus.BranchEn ? bus.Offset : PC_width'(1);

    pc_adder #(
        .PC_width (PC_width)
    ) u_pc_adder (
        .a   (pc_reg),
        .b   (step),
        .sum (pc_next)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            pc_reg      <= START_PC;
            done_reg    <= 1'b0;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    pc_reg      <= START_PC;
                    done_reg    <= 1'b0;
                    retired_reg <= '0;
                    if (!bus.Start) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (bus.Start) begin
                        state_reg   <= IDLE;
                        pc_reg      <= START_PC;
                        done_reg    <= 1'b0;
                        retired_reg <= '0;
                    end else if (!bus.Stall) begin
                        // The halt instruction itself retires but does not move the PC.
                        retired_reg <= sat_inc(retired_reg);
                        if (bus.Halt) begin
                            state_reg <= HALT;
                            done_reg  <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                HALT: begin
                    if (bus.Start) begin
                        state_reg   <= IDLE;
                        pc_reg      <= START_PC;
                        done_reg    <= 1'b0;
                        retired_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    pc_reg      <= START_PC;
                    done_reg    <= 1'b0;
                    retired_reg <= '0;
                end
            endcase
        end
    end

    assign bus.PC      = pc_reg;
    assign bus.Done    = done_reg;
    assign bus.Retired = retired_reg;

endmodule

// File: tb/tb_program_counter.sv
// Table-driven bench for program_counter with a scoreboard queue of expected
// PC/Done/Retired values, plus a long saturation run of the retired counter.
module tb_program_counter;
    import program_counter_pkg::*;

    localparam int W = 10;

    typedef struct {
        logic          reset;
        logic          start;
        logic          stall;
        logic          halt;
        logic          br;
        logic [W-1:0]  off;
        logic [W-1:0]  pc;
        logic          done;
        logic [15:0]   ret;
    } vec_t;

    typedef struct {
        int            tag;
        logic [W-1:0]  pc;
        logic          done;
        logic [15:0]   ret;
    } exp_t;

    logic clk;
    logic reset;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    program_counter_if #(.PC_width(W)) bus ();

    program_counter #(
        .PC_width   (W),
        .START_ADDR (0)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic s, input logic st, input logic h,
                                input logic b, input logic [W-1:0] off,
                                input logic [W-1:0] pc, input logic d, input logic [15:0] ret);
        vec_t v;
        v.reset = r;  v.start = s; v.stall = st; v.halt = h; v.br = b; v.off = off;
        v.pc    = pc; v.done  = d; v.ret   = ret;
        return v;
    endfunction

    task automatic add(input logic r, input logic s, input logic st, input logic h,
                       input logic b, input logic [W-1:0] off,
                       input logic [W-1:0] pc, input logic d, input logic [15:0] ret);
        tbl.push_back(mk(r, s, st, h, b, off, pc, d, ret));
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb_q.pop_front();
        n_vec++;
        if (bus.PC !== e.pc || bus.Done !== e.done || bus.Retired !== e.ret) begin
            n_err++;
            $display("FAIL vec %0d: got PC=%h Done=%b Retired=%h, expected PC=%h Done=%b Retired=%h",
                     e.tag, bus.PC, bus.Done, bus.Retired, e.pc, e.done, e.ret);
        end else begin
            $display("vec %0d ok: PC=%h Done=%b Retired=%h", e.tag, bus.PC, bus.Done, bus.Retired);
        end
    endtask

    // Drive one cycle of stimulus; the expected post-edge outputs are queued
    // at drive time and popped once the edge has been taken.
    task automatic step(input vec_t v, input bit chk, input int tag);
        exp_t e;
        @(negedge clk);
        reset        = v.reset;
        bus.Start    = v.start;
        bus.Stall    = v.stall;
        bus.Halt     = v.halt;
        bus.BranchEn = v.br;
        bus.Offset   = v.off;
        if (chk) begin
            e.tag = tag; e.pc = v.pc; e.done = v.done; e.ret = v.ret;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (chk) check();
    endtask

    initial begin
        reset        = 1'b1;
        bus.Start    = 1'b1;
        bus.Stall    = 1'b0;
        bus.Halt     = 1'b0;
        bus.BranchEn = 1'b0;
        bus.Offset   = '0;

        // reset, hold in IDLE, launch, four free cycles then one more to PC=5
        add(1, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        add(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        add(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 10'h000, W'(i), 0, 16'(i));
        // stall masks halt and branch
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 1, 10'h3FC, 10'h005, 0, 16'd5);
        // halt beats branch at PC=5
        add(0, 0, 0, 1, 1, 10'h3FC, 10'h005, 1, 16'd6);
        add(0, 0, 1, 0, 1, 10'h003, 10'h005, 1, 16'd6);
        add(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        // relaunch and walk to PC=8
        add(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        for (int i = 1; i <= 8; i++) add(0, 0, 0, 0, 0, 10'h000, W'(i), 0, 16'(i));
        add(0, 0, 0, 0, 1, 10'h3FC, 10'h004, 0, 16'd9);
        for (int i = 5; i <= 8; i++) add(0, 0, 0, 0, 0, 10'h000, W'(i), 0, 16'(i + 5));
        add(0, 0, 0, 0, 1, 10'h003, 10'h00B, 0, 16'd14);
        add(0, 0, 0, 0, 1, 10'h000, 10'h00B, 0, 16'd15);
        // abort from RUN
        add(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        add(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        // wrap both directions
        add(0, 0, 0, 0, 1, 10'h3FF, 10'h3FF, 0, 16'd1);
        add(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd2);
        // reset mid-RUN at 0x123, then stay idle under Start
        add(0, 0, 0, 0, 1, 10'h123, 10'h123, 0, 16'd3);
        add(1, 0, 0, 0, 1, 10'h005, 10'h000, 0, 16'd0);
        add(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);
        add(0, 1, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0);

        foreach (tbl[i]) step(tbl[i], 1'b1, i);

        // Saturation: self-loop branch retires every cycle without moving the PC.
        step(mk(0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0), 1'b1, 1000);
        for (int i = 0; i < 65534; i++)
            step(mk(0, 0, 0, 0, 1, 10'h000, 10'h000, 0, 16'd0), 1'b0, 0);
        step(mk(0, 0, 0, 0, 1, 10'h000, 10'h000, 0, 16'hFFFF), 1'b1, 1001);
        step(mk(0, 0, 0, 0, 1, 10'h000, 10'h000, 0, 16'hFFFF), 1'b1, 1002);
        step(mk(0, 0, 0, 0, 0, 10'h000, 10'h001, 0, 16'hFFFF), 1'b1, 1003);
        step(mk(0, 0, 0, 1, 0, 10'h000, 10'h001, 1, 16'hFFFF), 1'b1, 1004);
        // reset while halted
        step(mk(1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 16'd0), 1'b1, 1005);

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter PC_width, default 10, the width of the program counter and branch offset.
REQ-002 SHALL have parameter START_ADDR, default 0, the PC value loaded on reset and start.
REQ-003 SHALL have port Clk, input, 1, the single clock; every state change occurs on its rising edge.
REQ-004 SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, a level-sensitive start request: high holds the block in IDLE, and the high-to-low transition launches the program.
REQ-006 SHALL have port Stall, input, 1, which freezes the PC for the current cycle.
REQ-007 SHALL have port Halt, input, 1, the decoded halt instruction at the current PC.
REQ-008 SHALL have port BranchEn, input, 1, a taken relative branch at the current PC.
REQ-009 SHALL have port Offset, input, PC_width, the two's-complement relative target supplied by the immediate lookup stage.
REQ-010 SHALL have port PC, output, PC_width, the instruction-memory address, registered.
REQ-011 SHALL have port Done, output, 1, program-complete, registered.
REQ-012 SHALL have port Retired, output, 16, the retired-instruction count, registered.

Function
REQ-013 SHALL implement a three-state machine with states IDLE, RUN and HALT.
REQ-014 In IDLE, SHALL hold PC=START_ADDR, Retired=0 and Done=0.
REQ-015 SHALL move from IDLE to RUN on the first edge where Start=0.
REQ-016 In RUN with Stall=1, SHALL hold PC and Retired unchanged and ignore Halt and BranchEn.
REQ-017 In RUN with Stall=0 and Halt=1, SHALL hold PC, increment Retired, enter HALT and set Done=1 on the same edge.
REQ-018 In RUN with Stall=0, Halt=0 and BranchEn=1, SHALL set PC <= PC + Offset (modulo 2^PC_width) and increment Retired.
REQ-019 In RUN with Stall=0, Halt=0 and BranchEn=0, SHALL set PC <= PC + 1 (modulo 2^PC_width) and increment Retired.
REQ-020 SHALL apply update priority Reset > Start > Stall > Halt > BranchEn > sequential.
REQ-021 SHALL wrap PC silently in both directions: 0x3FF+1 -> 0x000, and 0x000 + 0x3FF -> 0x3FF.
REQ-022 SHALL accept Offset=0 while taken as a legal self-loop that still retires.
REQ-023 SHALL saturate Retired at 0xFFFF and never wrap it.
REQ-024 If Start=1 in RUN (abort), SHALL enter IDLE on the next edge, forcing PC=START_ADDR and Retired=0.
REQ-025 In HALT, SHALL hold PC, Retired and Done=1; Stall, Halt and BranchEn are ignored.
REQ-026 SHALL leave HALT only when Start=1, which takes it to IDLE with Done=0 next cycle.
REQ-027 SHALL apply each update with one-cycle latency: PC reflects a decision on the edge following the sampled inputs.
REQ-028 SHALL drive all outputs from flops, with no combinational input-to-output path.

Reset
REQ-029 When Reset=1 at an edge, SHALL enter IDLE with PC=START_ADDR, Done=0 and Retired=0, regardless of state, including mid-RUN and in HALT.
REQ-030 After Reset deasserts, SHALL remain in IDLE while Start=1.

Structure
REQ-031 SHALL take the state enum (IDLE, RUN, HALT) and the PC_width default constant from the shared processor package.
REQ-032 SHALL contain at most one sub-module, named pc_adder (the PC_width-bit wrap-around adder for sequential and relative targets); everything else is inline.

Verification
REQ-033 Bench SHALL cover: Reset, Start 1->0, four free cycles -> PC sequence 0,1,2,3,4 and Retired=4.
REQ-034 Bench SHALL cover: at PC=8, BranchEn=1 with Offset=0x3FC -> PC=4 next cycle; with Offset=0x003 -> PC=11.
REQ-035 Bench SHALL cover: Stall=1 together with Halt=1 and BranchEn=1 for 3 cycles -> PC and Retired frozen, Done=0; Halt then honoured once Stall drops.
REQ-036 Bench SHALL cover: Halt=1 together with BranchEn=1 at PC=5 -> PC stays 5, Done=1, Retired+1; Start=1 -> IDLE with Done=0 and PC=0.
REQ-037 Bench SHALL cover: PC=0x3FF sequential -> 0x000; at PC=0, Offset=0x3FF -> PC=0x3FF; Retired preloaded to 0xFFFF by running long -> stays 0xFFFF.
REQ-038 Bench SHALL cover: Reset asserted mid-RUN at PC=0x123 -> next cycle PC=0, Done=0, Retired=0, state IDLE while Start=1.
